// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared bus-cycle state encoding and bus direction constants
package ext_bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, SETUP, STROBE, HOLD, DONE} bus_state_e;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/bus_phase_timer.sv
// bus_phase_timer: down-counter timing the STROBE and HOLD phases
// Ports: clk, rst, load (load_val into counter), load_val [W-1:0], expire (count is zero)
module bus_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign expire = cnt_q == '0;
endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: shares one multiplexed ALE/En/Rw external bus between core (0) and display (1)
// Ports: clk, rst, pause; req/rw/addr/wdata in and done out per requester; rdata, busy;
//        bus pins ale, en, rw, ad_out, ad_oe, ad_in
// ARB_ROUND_ROBIN_EN: when defined, ties go to the requester other than the last winner;
//        otherwise req0 always beats req1
module ext_bus_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int EN_CYCLES   = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pause,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ale,
  output logic          en,
  output logic          rw,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [DW-1:0] ad_in
);
  import ext_bus_pkg::*;

  localparam int TMAX = EN_CYCLES > HOLD_CYCLES ? EN_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  if (EN_CYCLES < 1) begin : g_chk_en
    $error("EN_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (DW < AW) begin : g_chk_dw
    $error("DW must be >= AW");
  end

  bus_state_e    state_q, state_d;
  logic          gnt_q, gnt_d, lrw_q, lrw_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic [DW-1:0] lwdata_q, lwdata_d, rdata_q, rdata_d, ad_out_q, ad_out_d;
  logic          ale_q, ale_d, en_q, en_d, rw_q, rw_d, ad_oe_q, ad_oe_d;
  logic          done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic          grant, pick, tload, expire, phase, drive;
  logic [TW-1:0] tval;

  assign grant = state_q == IDLE && !pause && (req0 || req1);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick   = (req0 && req1) ? ~last_q : ~req0;
  assign last_d = grant ? pick : last_q;
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign pick = ~req0;
`endif

  bus_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .expire   (expire)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    lrw_d    = lrw_q;
    laddr_d  = laddr_q;
    lwdata_d = lwdata_q;
    rdata_d  = rdata_q;
    tload    = 1'b0;
    tval     = TW'(EN_CYCLES - 1);
    case (state_q)
      IDLE: if (grant) begin
        state_d  = ADDR;
        gnt_d    = pick;
        lrw_d    = pick ? rw1 : rw0;
        laddr_d  = pick ? addr1 : addr0;
        lwdata_d = pick ? wdata1 : wdata0;
      end
      ADDR:  state_d = SETUP;
      SETUP: begin
        state_d = STROBE;
        tload   = 1'b1;
      end
      STROBE: if (expire) begin
        state_d = HOLD;
        tload   = 1'b1;
        tval    = TW'(HOLD_CYCLES - 1);
        rdata_d = lrw_q == RW_READ ? ad_in : rdata_q;
      end
      HOLD: if (expire) state_d = DONE;
      DONE: if (!(gnt_q ? req1 : req0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pin outputs are registered from the next state so they line up with it.
    phase    = state_d inside {ADDR, SETUP, STROBE, HOLD};
    drive    = phase && (state_d == ADDR || lrw_d == RW_WRITE);
    ale_d    = state_d == ADDR;
    en_d     = state_d == STROBE;
    rw_d     = phase ? lrw_d : RW_READ;
    ad_oe_d  = drive;
    ad_out_d = state_d == ADDR ? DW'(laddr_d) : (drive ? lwdata_d : '0);
    done0_d  = state_d == DONE && !gnt_d;
    done1_d  = state_d == DONE && gnt_d;
    busy_d   = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      lrw_q    <= RW_READ;
      laddr_q  <= '0;
      lwdata_q <= '0;
      rdata_q  <= '0;
      ale_q    <= 1'b0;
      en_q     <= 1'b0;
      rw_q     <= RW_READ;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      lrw_q    <= lrw_d;
      laddr_q  <= laddr_d;
      lwdata_q <= lwdata_d;
      rdata_q  <= rdata_d;
      ale_q    <= ale_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign ale    = ale_q;
  assign en     = en_q;
  assign rw     = rw_q;
  assign ad_oe  = ad_oe_q;
  assign ad_out = ad_out_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: randomized and directed checks of ext_bus_arbiter against a transaction model
module tb_ext_bus_arbiter;
  localparam int AW = 8, DW = 8, EN = 2, HOLD = 1;

  logic          clk = 1'b0, rst = 1'b1, pause = 1'b0;
  logic          req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, ad_in = '0;
  logic          done0, done1, busy, ale, en, rw, ad_oe;
  logic [DW-1:0] rdata, ad_out;

  ext_bus_arbiter #(.AW(AW), .DW(DW), .EN_CYCLES(EN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .busy(busy), .ale(ale), .en(en), .rw(rw),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_err = 0;
  bit            last_m = 1'b1;
  bit            e_rw[2];
  logic [AW-1:0] e_addr[2];
  logic [DW-1:0] e_wdata[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input bit rwv, input logic [AW-1:0] a, input logic [DW-1:0] w);
    e_rw[id] = rwv; e_addr[id] = a; e_wdata[id] = w;
    if (id == 0) begin req0 = 1'b1; rw0 = rwv; addr0 = a; wdata0 = w; end
    else         begin req1 = 1'b1; rw1 = rwv; addr1 = a; wdata1 = w; end
  endtask

  task automatic rnd_req(input int id);
    set_req(id, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  // Winner of an arbitration given which requests are up at the grant edge.
  function automatic int pick(input bit r0, input bit r1);
`ifdef ARB_ROUND_ROBIN_EN
    if (r0 && r1) return last_m ? 0 : 1;
`else
    if (r0 && r1) return 0;
`endif
    return r0 ? 0 : 1;
  endfunction

  // Follows one whole bus cycle of requester id, starting from the negedge where its request is up.
  task automatic xfer(input int id, input int maxw, input bit pause_mid, input logic [DW-1:0] din);
    bit erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    int n;
    erw = e_rw[id]; ea = e_addr[id]; ew = e_wdata[id];
    n = 0;
    do begin @(negedge clk); n++; end while (!ale && n < maxw);
    check("ale_wait", 32'(ale), 1);
    if (!ale) begin drop_req(id); return; end
    check("addr_en", 32'(en), 0);
    check("addr_oe", 32'(ad_oe), 1);
    check("addr_ad", 32'(ad_out), 32'(ea));
    check("addr_rw", 32'(rw), 32'(erw));
    check("addr_busy", 32'(busy), 1);
    check("addr_done", 32'({done0, done1}), 0);
    ad_in = din;
    // Only the grant edge counts: the requester may now change its inputs freely.
    if (id == 0) {rw0, addr0, wdata0} = 17'($urandom);
    else         {rw1, addr1, wdata1} = 17'($urandom);
    @(negedge clk);
    check("setup_ale", 32'(ale), 0);
    check("setup_en", 32'(en), 0);
    check("setup_oe", 32'(ad_oe), 32'(!erw));
    check("setup_rw", 32'(rw), 32'(erw));
    if (!erw) check("setup_ad", 32'(ad_out), 32'(ew));
    if (pause_mid) pause = 1'b1;
    for (int i = 0; i < EN; i++) begin
      @(negedge clk);
      check("strobe_en", 32'(en), 1);
      check("strobe_oe", 32'(ad_oe), 32'(!erw));
      check("strobe_rw", 32'(rw), 32'(erw));
      if (!erw) check("strobe_ad", 32'(ad_out), 32'(ew));
    end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check("hold_en", 32'(en), 0);
      check("hold_oe", 32'(ad_oe), 32'(!erw));
      check("hold_busy", 32'(busy), 1);
      if (!erw) check("hold_ad", 32'(ad_out), 32'(ew));
    end
    @(negedge clk);
    check("done0", 32'(done0), 32'(id == 0));
    check("done1", 32'(done1), 32'(id == 1));
    check("done_oe", 32'(ad_oe), 0);
    check("done_rw", 32'(rw), 1);
    check("done_busy", 32'(busy), 1);
    if (erw) check("rdata", 32'(rdata), 32'(din));
    ad_in = ~din;
    drop_req(id);
    @(negedge clk);
    check("idle_done", 32'({done0, done1}), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  // Serves the raised requests; each requester re-requests until it has had l0 / l1 grants.
  task automatic serve(input int l0, input int l1);
    int left[2];
    int id;
    left[0] = l0; left[1] = l1;
    while (req0 || req1) begin
      id = pick(req0, req1);
      last_m = id[0];
      xfer(id, 3, 1'b0, DW'($urandom));
      left[id]--;
      if (left[id] > 0) rnd_req(id);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ale", 32'(ale), 0);
    check("rst_en", 32'(en), 0);
    check("rst_rw", 32'(rw), 1);
    check("rst_oe", 32'(ad_oe), 0);
    check("rst_ad", 32'(ad_out), 0);
    check("rst_done", 32'({done0, done1}), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Core read, then display write.
    set_req(0, 1'b1, 8'h3C, 8'h00);
    last_m = 1'b0;
    xfer(0, 3, 1'b0, 8'hA5);
    set_req(1, 1'b0, 8'h10, 8'h5A);
    last_m = 1'b1;
    xfer(1, 3, 1'b0, 8'h33);

    // Both requesters hammer the bus three times each.
    rnd_req(0); rnd_req(1);
    serve(3, 3);

    // Pause blocks grants until released, then the grant is immediate.
    pause = 1'b1;
    rnd_req(1);
    repeat (20) begin
      @(negedge clk);
      check("pause_ale", 32'(ale), 0);
      check("pause_busy", 32'(busy), 0);
    end
    pause = 1'b0;
    last_m = 1'b1;
    xfer(1, 1, 1'b0, DW'($urandom));

    // Reset in the middle of a strobe aborts the cycle.
    set_req(0, 1'b0, 8'h44, 8'h99);
    @(negedge clk);
    check("rstcyc_ale", 32'(ale), 1);
    repeat (2) @(negedge clk);
    check("rstcyc_en", 32'(en), 1);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("abort_en", 32'(en), 0);
    check("abort_oe", 32'(ad_oe), 0);
    check("abort_rw", 32'(rw), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_ale", 32'(ale), 0);
    check("abort_ad", 32'(ad_out), 0);
    rst = 1'b0;
    last_m = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_nodone", 32'({done0, done1}), 0);
    end
    rnd_req(0);
    serve(1, 0);

    // Pause raised mid-cycle: the cycle finishes, then nothing new starts.
    set_req(1, 1'b0, 8'h21, 8'hC3);
    last_m = 1'b1;
    xfer(1, 3, 1'b1, 8'h00);
    rnd_req(0);
    repeat (10) begin
      @(negedge clk);
      check("pmid_ale", 32'(ale), 0);
    end
    pause = 1'b0;
    last_m = 1'b0;
    xfer(0, 1, 1'b0, DW'($urandom));

    // Random traffic mix.
    for (int k = 0; k < 30; k++) begin
      int pat;
      pat = int'($urandom_range(0, 2));
      if (pat != 1) rnd_req(0);
      if (pat != 0) rnd_req(1);
      serve(1 + int'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
